rgb_strip_driver: RTL



---
 rtl/rgb_pkg.sv | 17 +
 rtl/rgb_fifo.sv | 54 +++++
 rtl/rgb_strip_driver.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB LED strip driver.
// Holds the controller state encoding and the default values of the
// top-level parameters (pixel word width, FIFO depth, timing field width).
package rgb_pkg;

    localparam int RGB_DATA_W_DEF     = 24;
    localparam int RGB_FIFO_DEPTH_DEF = 8;
    localparam int RGB_CNT_W_DEF      = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_BIT   = 2'd2,
        ST_LATCH = 2'd3
    } rgb_state_t;

endpackage

// File: rtl/rgb_fifo.sv
// Synchronous show-ahead FIFO holding pixel words plus their frame-end flag.
// Ports:
//   i_clk, i_reset         clock, synchronous active-high reset (empties FIFO)
//   i_wr_en, i_wr_data     write strobe and word; ignored while full
//   i_rd_en                pop strobe; ignored while empty
//   o_rd_data              word at the head (valid whenever !o_empty)
//   o_full, o_empty        occupancy flags
module rgb_fifo
    import rgb_pkg::*;
#(
    parameter int WORD_W     = RGB_DATA_W_DEF + 1,
    parameter int FIFO_DEPTH = RGB_FIFO_DEPTH_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr_en,
    input  logic [WORD_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic [WORD_W-1:0] o_rd_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]       r_wptr;
    logic [AW:0]       r_rptr;
    logic              w_push;
    logic              w_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) &&
                       (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_rd_data = r_mem[r_rptr[AW-1:0]];
    assign w_push    = i_wr_en && !o_full;
    assign w_pop     = i_rd_en && !o_empty;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wr_data;
    end

endmodule

// File: rtl/rgb_strip_driver.sv
// Serial driver for single-wire RGB LED strips. Pixel words are queued in a
// FIFO and shifted out MSB first; every bit is a period of clk_max ticks that
// starts high for hi_in_1 / hi_in_0 ticks. A frame ends with a low latch
// period of latch_len ticks. A tick occurs every clk_div+1 clk cycles.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   enable                      allows a new frame to start from IDLE
//   clk_div, clk_max            prescaler and bit period (timing fields)
//   hi_in_1, hi_in_0, latch_len high times per bit value, frame latch time
//   s_valid/s_data/s_last/s_ready  pixel write port (s_ready = !fifo_full)
//   out                         registered serial line
//   no_pulse, busy              state indications
// Optional feature macro RGB_UNDERRUN_EN adds:
//   underrun_clr (in), underrun (out, sticky FIFO-underrun flag)
module rgb_strip_driver
    import rgb_pkg::*;
#(
    parameter int DATA_W     = RGB_DATA_W_DEF,
    parameter int FIFO_DEPTH = RGB_FIFO_DEPTH_DEF,
    parameter int CNT_W      = RGB_CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [7:0]        clk_div,
    input  logic [CNT_W-1:0]  clk_max,
    input  logic [CNT_W-1:0]  hi_in_1,
    input  logic [CNT_W-1:0]  hi_in_0,
    input  logic [CNT_W-1:0]  latch_len,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
`ifdef RGB_UNDERRUN_EN
    input  logic              underrun_clr,
    output logic              underrun,
`endif
    output logic              out,
    output logic              no_pulse,
    output logic              busy
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    rgb_state_t        r_state, w_state_nxt;
    logic [7:0]        r_div, r_presc, w_presc_nxt;
    logic [CNT_W-1:0]  r_max, r_hi1, r_hi0, r_latch;
    logic [CNT_W-1:0]  r_tcnt, w_tcnt_nxt;
    logic [DATA_W-1:0] r_shift, w_shift_nxt;
    logic [BIT_W-1:0]  r_bit, w_bit_nxt;
    logic              r_last, w_last_nxt;
    logic              r_out;
    logic              w_tick, w_pop, w_load, w_out_nxt;
    logic              w_full, w_empty;
    logic [DATA_W:0]   w_rd_word;
    logic [CNT_W-1:0]  w_hi1_nxt, w_hi0_nxt, w_hi_nxt;

    assign s_ready  = !w_full;
    assign out      = r_out;
    assign no_pulse = (r_state == ST_IDLE) || (r_state == ST_LATCH);
    assign busy     = (r_state != ST_IDLE);

    rgb_fifo #(
        .WORD_W     (DATA_W + 1),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_wr_en   (s_valid),
        .i_wr_data ({s_last, s_data}),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_word),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign w_tick = (r_presc == r_div);

    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = r_presc;
        w_tcnt_nxt  = r_tcnt;
        w_shift_nxt = r_shift;
        w_bit_nxt   = r_bit;
        w_last_nxt  = r_last;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable && !w_empty) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                w_pop       = 1'b1;
                w_load      = 1'b1;
                w_shift_nxt = w_rd_word[DATA_W-1:0];
                w_last_nxt  = w_rd_word[DATA_W];
                w_bit_nxt   = BIT_W'(DATA_W - 1);
                w_presc_nxt = '0;
                w_tcnt_nxt  = '0;
                w_state_nxt = ST_BIT;
            end
            ST_BIT: begin
                w_presc_nxt = w_tick ? 8'd0 : r_presc + 8'd1;
                if (w_tick) begin
                    if (r_tcnt == r_max - CNT_W'(1)) begin
                        w_tcnt_nxt = '0;
                        if (r_bit == '0) begin
                            // Chain the next word without a gap unless the
                            // frame ended or the FIFO ran dry (underrun).
                            if (!r_last && !w_empty) begin
                                w_pop       = 1'b1;
                                w_shift_nxt = w_rd_word[DATA_W-1:0];
                                w_last_nxt  = w_rd_word[DATA_W];
                                w_bit_nxt   = BIT_W'(DATA_W - 1);
                            end else begin
                                w_state_nxt = ST_LATCH;
                            end
                        end else begin
                            w_shift_nxt = r_shift << 1;
                            w_bit_nxt   = r_bit - 1'b1;
                        end
                    end else begin
                        w_tcnt_nxt = r_tcnt + CNT_W'(1);
                    end
                end
            end
            ST_LATCH: begin
                w_presc_nxt = w_tick ? 8'd0 : r_presc + 8'd1;
                if (w_tick) begin
                    if (r_tcnt == r_latch - CNT_W'(1)) w_state_nxt = ST_IDLE;
                    else                               w_tcnt_nxt  = r_tcnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // The line is registered from next-state values so it stays aligned with
    // the tick counter; the LOAD edge uses the freshly sampled high times.
    assign w_hi1_nxt = w_load ? hi_in_1 : r_hi1;
    assign w_hi0_nxt = w_load ? hi_in_0 : r_hi0;
    assign w_hi_nxt  = w_shift_nxt[DATA_W-1] ? w_hi1_nxt : w_hi0_nxt;
    assign w_out_nxt = (w_state_nxt == ST_BIT) && (w_tcnt_nxt < w_hi_nxt);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_presc <= '0;
            r_tcnt  <= '0;
            r_shift <= '0;
            r_bit   <= '0;
            r_last  <= 1'b0;
            r_out   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_presc <= w_presc_nxt;
            r_tcnt  <= w_tcnt_nxt;
            r_shift <= w_shift_nxt;
            r_bit   <= w_bit_nxt;
            r_last  <= w_last_nxt;
            r_out   <= w_out_nxt;
        end
    end

    // Timing shadows are frame-constant; zero period/latch lengths mean one tick.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_div   <= clk_div;
            r_max   <= (clk_max == '0) ? CNT_W'(1) : clk_max;
            r_hi1   <= hi_in_1;
            r_hi0   <= hi_in_0;
            r_latch <= (latch_len == '0) ? CNT_W'(1) : latch_len;
        end
    end

`ifdef RGB_UNDERRUN_EN
    logic r_underrun;
    logic w_underrun_evt;

    assign w_underrun_evt = (r_state == ST_BIT) && w_tick &&
                            (r_tcnt == r_max - CNT_W'(1)) && (r_bit == '0) &&
                            !r_last && w_empty;
    assign underrun = r_underrun;

    always_ff @(posedge clk) begin
        if (reset)               r_underrun <= 1'b0;
        else if (w_underrun_evt) r_underrun <= 1'b1;
        else if (underrun_clr)   r_underrun <= 1'b0;
    end
`endif

endmodule
